// File: rtl/smem_ctx_mem_queue.sv
// smem_ctx_mem_queue: pairs delayed pipeline contexts with DRAM responses and re-issues them to the pipeline head
module smem_ctx_mem_queue #(
  parameter int CTX_W = 292,
  parameter int QRY_W = 8,
  parameter int MEM_W = 768,
  parameter int CTX_DEPTH = 256,
  parameter int MEM_DEPTH = 32,
  parameter int QRY_LAT = 3,
  parameter int AF_MARGIN = 8,
  parameter logic [7:0] ACCEPT_MASK = 8'h07
) (
  input  logic                         Clk_32UI,
  input  logic                         reset_n,
  input  logic                         stall,
  input  logic [5:0]                   in_status,
  input  logic [CTX_W-1:0]             in_ctx,
  input  logic [6:0]                   in_fwd_i,
  input  logic [9:0]                   in_read_num,
  output logic [6:0]                   qry_pos_2RAM,
  output logic [9:0]                   qry_read_2RAM,
  input  logic [QRY_W-1:0]             qry_data,
  input  logic                         mem_valid,
  input  logic [MEM_W-1:0]             mem_data,
  input  logic                         new_read_valid,
  input  logic                         load_done,
  input  logic [CTX_W-1:0]             new_ctx,
  output logic                         new_read_ack,
  output logic [5:0]                   out_status,
  output logic [CTX_W-1:0]             out_ctx,
  output logic [QRY_W-1:0]             out_query,
  output logic [MEM_W-1:0]             out_mem,
  output logic [$clog2(CTX_DEPTH):0]   ctx_count,
  output logic                         ctx_afull,
  output logic                         err_ctx_ovf,
  output logic                         err_mem_ovf,
  output logic                         err_orphan
);
  localparam int CA = $clog2(CTX_DEPTH);
  localparam int MA = $clog2(MEM_DEPTH);
  localparam int EW = CTX_W + QRY_W + 6;
  localparam logic [5:0] BUBBLE = 6'h30;
  localparam logic [MEM_W-1:0] MEM_FILL = {(MEM_W/4){4'h1}};
  localparam logic [CA:0] AF_TH = (CA+1)'(CTX_DEPTH - AF_MARGIN);

  logic [5:0]       dl_st_q [QRY_LAT];
  logic [5:0]       dl_st_d [QRY_LAT];
  logic [CTX_W-1:0] dl_ctx_q [QRY_LAT];
  logic [CTX_W-1:0] dl_ctx_d [QRY_LAT];
  logic [EW-1:0]    ctx_mem [CTX_DEPTH];
  logic [MEM_W-1:0] mem_mem [MEM_DEPTH];
  logic [CA:0]      cwr_q, cwr_d, crd_q, crd_d;
  logic [MA:0]      mwr_q, mwr_d, mrd_q, mrd_d, mem_cnt;
  logic             err_ctx_ovf_q, err_ctx_ovf_d, err_mem_ovf_q, err_mem_ovf_d, err_orphan_q, err_orphan_d;
  logic [5:0]       out_status_q, out_status_d;
  logic [CTX_W-1:0] out_ctx_q, out_ctx_d;
  logic [QRY_W-1:0] out_query_q, out_query_d;
  logic [MEM_W-1:0] out_mem_q, out_mem_d;
  logic [5:0]       stage_st;
  logic             accept, ctx_empty, ctx_full, mem_empty, mem_full, pair, ctx_wr_req, ctx_wr, mem_wr;
  logic [EW-1:0]    ctx_head;
  logic [MEM_W-1:0] mem_head;

  assign qry_pos_2RAM  = in_fwd_i + 7'd1;
  assign qry_read_2RAM = in_read_num;
  assign stage_st  = dl_st_q[QRY_LAT-1];
  assign accept    = (stage_st[5:3] == 3'b000) && ACCEPT_MASK[stage_st[2:0]];
  assign ctx_count = cwr_q - crd_q;
  assign mem_cnt   = mwr_q - mrd_q;
  assign ctx_empty = ctx_count == '0;
  assign ctx_full  = ctx_count[CA];
  assign mem_empty = mem_cnt == '0;
  assign mem_full  = mem_cnt[MA];
  assign ctx_afull = ctx_count >= AF_TH;
  assign ctx_head  = ctx_mem[crd_q[CA-1:0]];
  assign mem_head  = mem_mem[mrd_q[MA-1:0]];
  assign out_status  = out_status_q;
  assign out_ctx     = out_ctx_q;
  assign out_query   = out_query_q;
  assign out_mem     = out_mem_q;
  assign err_ctx_ovf = err_ctx_ovf_q;
  assign err_mem_ovf = err_mem_ovf_q;
  assign err_orphan  = err_orphan_q;

  // delay line shifts tail contexts forward while the query RAM lookup completes
  always_comb begin
    dl_st_d  = dl_st_q;
    dl_ctx_d = dl_ctx_q;
    if (!stall) begin
      dl_st_d[0]  = in_status;
      dl_ctx_d[0] = in_ctx;
      for (int i = 1; i < QRY_LAT; i++) begin
        dl_st_d[i]  = dl_st_q[i-1];
        dl_ctx_d[i] = dl_ctx_q[i-1];
      end
    end
  end

  // queue control: pairing, writes that may land on a full FIFO being popped, sticky errors, head mux
  always_comb begin
    pair          = !stall && !mem_empty && !ctx_empty;
    ctx_wr_req    = !stall && accept;
    ctx_wr        = ctx_wr_req && (!ctx_full || pair);
    mem_wr        = mem_valid && (!mem_full || pair);
    new_read_ack  = !stall && load_done && new_read_valid && mem_empty;
    cwr_d         = cwr_q + (CA+1)'(ctx_wr);
    crd_d         = crd_q + (CA+1)'(pair);
    mwr_d         = mwr_q + (MA+1)'(mem_wr);
    mrd_d         = mrd_q + (MA+1)'(pair);
    err_ctx_ovf_d = err_ctx_ovf_q || (ctx_wr_req && !ctx_wr);
    err_mem_ovf_d = err_mem_ovf_q || (mem_valid && !mem_wr);
    err_orphan_d  = err_orphan_q || (!stall && !mem_empty && ctx_empty);
    out_status_d  = stall ? out_status_q : pair ? ctx_head[5:0] : new_read_ack ? 6'd0 : BUBBLE;
    out_ctx_d     = stall ? out_ctx_q : pair ? ctx_head[EW-1 -: CTX_W] : new_read_ack ? new_ctx : '1;
    out_query_d   = stall ? out_query_q : pair ? ctx_head[6 +: QRY_W] : new_read_ack ? '0 : '1;
    out_mem_d     = stall ? out_mem_q : pair ? mem_head : MEM_FILL;
  end

  // state registers; reset flushes both queues and the delay line without draining
  always_ff @(posedge Clk_32UI) begin
    if (!reset_n) begin
      for (int i = 0; i < QRY_LAT; i++) dl_st_q[i] <= BUBBLE;
      cwr_q         <= '0;
      crd_q         <= '0;
      mwr_q         <= '0;
      mrd_q         <= '0;
      err_ctx_ovf_q <= 1'b0;
      err_mem_ovf_q <= 1'b0;
      err_orphan_q  <= 1'b0;
      out_status_q  <= BUBBLE;
      out_ctx_q     <= '1;
      out_query_q   <= '1;
      out_mem_q     <= MEM_FILL;
    end else begin
      dl_st_q       <= dl_st_d;
      cwr_q         <= cwr_d;
      crd_q         <= crd_d;
      mwr_q         <= mwr_d;
      mrd_q         <= mrd_d;
      err_ctx_ovf_q <= err_ctx_ovf_d;
      err_mem_ovf_q <= err_mem_ovf_d;
      err_orphan_q  <= err_orphan_d;
      out_status_q  <= out_status_d;
      out_ctx_q     <= out_ctx_d;
      out_query_q   <= out_query_d;
      out_mem_q     <= out_mem_d;
    end
  end

  // payload storage needs no reset: validity is tracked by status and pointers
  always_ff @(posedge Clk_32UI) begin
    dl_ctx_q <= dl_ctx_d;
    if (ctx_wr) ctx_mem[cwr_q[CA-1:0]] <= {dl_ctx_q[QRY_LAT-1], qry_data, stage_st};
    if (mem_wr) mem_mem[mwr_q[MA-1:0]] <= mem_data;
  end
endmodule

// File: tb/tb_smem_ctx_mem_queue.sv
// tb_smem_ctx_mem_queue: scoreboard bench for the context/response pairing queue
module tb_smem_ctx_mem_queue;
  localparam int CTX_W = 292;
  localparam int QRY_W = 8;
  localparam int MEM_W = 768;
  localparam logic [5:0] BUB = 6'h30;
  localparam logic [MEM_W-1:0] FILL = {192{4'h1}};

  typedef struct packed {
    logic [5:0]       st;
    logic [CTX_W-1:0] ctx;
    logic [7:0]       q;
  } exp_t;

  logic Clk_32UI = 1'b0;
  logic reset_n = 1'b0, stall = 1'b0;
  logic [5:0] in_status = BUB;
  logic [CTX_W-1:0] in_ctx = '0, new_ctx = '0;
  logic [6:0] in_fwd_i = '0;
  logic [9:0] in_read_num = '0;
  logic [6:0] qry_pos_2RAM;
  logic [9:0] qry_read_2RAM;
  logic [QRY_W-1:0] qry_data;
  logic mem_valid = 1'b0, new_read_valid = 1'b0, load_done = 1'b0;
  logic [MEM_W-1:0] mem_data = '0;
  logic new_read_ack, ctx_afull, err_ctx_ovf, err_mem_ovf, err_orphan;
  logic [5:0] out_status;
  logic [CTX_W-1:0] out_ctx;
  logic [QRY_W-1:0] out_query;
  logic [MEM_W-1:0] out_mem;
  logic [8:0] ctx_count;

  exp_t cq[$];
  logic [MEM_W-1:0] mq[$];
  int checks = 0, passed = 0;
  logic [7:0] qp [3];

  smem_ctx_mem_queue dut (
    .Clk_32UI(Clk_32UI), .reset_n(reset_n), .stall(stall), .in_status(in_status), .in_ctx(in_ctx),
    .in_fwd_i(in_fwd_i), .in_read_num(in_read_num), .qry_pos_2RAM(qry_pos_2RAM), .qry_read_2RAM(qry_read_2RAM),
    .qry_data(qry_data), .mem_valid(mem_valid), .mem_data(mem_data), .new_read_valid(new_read_valid),
    .load_done(load_done), .new_ctx(new_ctx), .new_read_ack(new_read_ack), .out_status(out_status),
    .out_ctx(out_ctx), .out_query(out_query), .out_mem(out_mem), .ctx_count(ctx_count), .ctx_afull(ctx_afull),
    .err_ctx_ovf(err_ctx_ovf), .err_mem_ovf(err_mem_ovf), .err_orphan(err_orphan)
  );

  always #5 Clk_32UI = ~Clk_32UI;

  function automatic logic [7:0] qf(input logic [9:0] r, input logic [6:0] p);
    return r[7:0] + {1'b0, p};
  endfunction

  always @(posedge Clk_32UI) begin
    qp[0] <= qf(qry_read_2RAM, qry_pos_2RAM);
    qp[1] <= qp[0];
    qp[2] <= qp[1];
  end
  assign qry_data = qp[2];

  function automatic logic [CTX_W-1:0] rnd_ctx();
    logic [319:0] t = '0;
    for (int i = 0; i < 10; i++) t = {t[287:0], 32'($urandom)};
    return t[CTX_W-1:0];
  endfunction

  function automatic logic [MEM_W-1:0] rnd_mem();
    logic [MEM_W-1:0] t = '0;
    for (int i = 0; i < 24; i++) t = {t[MEM_W-33:0], 32'($urandom)};
    return t;
  endfunction

  task automatic tick();
    @(posedge Clk_32UI);
    #1;
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stall = 1'b0; mem_valid = 1'b0; new_read_valid = 1'b0; load_done = 1'b0; in_status = BUB;
    tick(); tick();
    reset_n = 1'b1;
    cq.delete(); mq.delete();
  endtask

  task automatic drive_ctx(input logic [5:0] st, input logic [6:0] fwd, input logic [9:0] rd, input bit keep);
    exp_t e;
    e.st = st; e.ctx = rnd_ctx(); e.q = qf(rd, fwd + 7'd1);
    in_status = st; in_ctx = e.ctx; in_fwd_i = fwd; in_read_num = rd;
    if (keep && st < 6'd3) cq.push_back(e);
    tick();
    in_status = BUB;
  endtask

  task automatic test_reset();
    do_reset();
    tick(); tick();
    checks++; if (out_status !== BUB) $display("FAIL reset_status got %h exp %h", out_status, BUB); else passed++;
    checks++; if (ctx_count !== 9'd0) $display("FAIL reset_count got %0d exp 0", ctx_count); else passed++;
    checks++; if ({err_ctx_ovf, err_mem_ovf, err_orphan, ctx_afull} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {err_ctx_ovf, err_mem_ovf, err_orphan, ctx_afull}); else passed++;
    checks++; if ({out_ctx, out_query} !== '1) $display("FAIL reset_fill got %h/%h exp all-ones", out_ctx, out_query); else passed++;
    checks++; if (out_mem !== FILL) $display("FAIL reset_mem got %h exp %h", out_mem, FILL); else passed++;
  endtask

  task automatic test_new_read();
    logic [CTX_W-1:0] x = rnd_ctx();
    new_ctx = x; load_done = 1'b1; new_read_valid = 1'b1;
    #1;
    checks++; if (new_read_ack !== 1'b1) $display("FAIL nr_ack got %b exp 1", new_read_ack); else passed++;
    tick();
    new_read_valid = 1'b0;
    #1;
    checks++; if ({out_status, out_query} !== 14'd0) $display("FAIL nr_stq got %h/%h exp 00/00", out_status, out_query); else passed++;
    checks++; if (out_ctx !== x) $display("FAIL nr_ctx got %h exp %h", out_ctx, x); else passed++;
    checks++; if (out_mem !== FILL) $display("FAIL nr_mem got %h exp %h", out_mem, FILL); else passed++;
    checks++; if (new_read_ack !== 1'b0) $display("FAIL nr_ack_drop got %b exp 0", new_read_ack); else passed++;
    load_done = 1'b0; new_read_valid = 1'b1;
    #1;
    checks++; if (new_read_ack !== 1'b0) $display("FAIL nr_noload_ack got %b exp 0", new_read_ack); else passed++;
    tick();
    new_read_valid = 1'b0;
    checks++; if (out_status !== BUB) $display("FAIL nr_noload_status got %h exp %h", out_status, BUB); else passed++;
  endtask

  task automatic test_pair();
    exp_t e;
    logic [MEM_W-1:0] m;
    in_fwd_i = 7'd127;
    #1;
    checks++; if (qry_pos_2RAM !== 7'd0) $display("FAIL qry_wrap got %h exp 00", qry_pos_2RAM); else passed++;
    in_fwd_i = 7'd1; in_read_num = 10'd0;
    #1;
    checks++; if ({qry_pos_2RAM, qry_read_2RAM} !== {7'd2, 10'd0}) $display("FAIL qry_req got %h/%h exp 02/000", qry_pos_2RAM, qry_read_2RAM); else passed++;
    drive_ctx(6'd1, 7'd1, 10'd0, 1'b1);
    drive_ctx(6'd3, 7'd5, 10'd9, 1'b1);
    settle();
    checks++; if (ctx_count !== 9'd1) $display("FAIL pair_count1 got %0d exp 1", ctx_count); else passed++;
    mq.push_back(rnd_mem());
    mem_data = mq[$]; mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    checks++; if (out_status !== BUB) $display("FAIL pair_early got %h exp %h", out_status, BUB); else passed++;
    tick();
    e = cq.pop_front(); m = mq.pop_front();
    checks++; if ({out_status, out_query} !== {6'd1, 8'h02}) $display("FAIL pair_stq got %h/%h exp 01/02", out_status, out_query); else passed++;
    checks++; if (out_ctx !== e.ctx) $display("FAIL pair_ctx got %h exp %h", out_ctx, e.ctx); else passed++;
    checks++; if (out_mem !== m) $display("FAIL pair_mem got %h exp %h", out_mem, m); else passed++;
    checks++; if (ctx_count !== 9'd0) $display("FAIL pair_count0 got %0d exp 0", ctx_count); else passed++;
  endtask

  task automatic test_fill();
    exp_t e;
    logic [MEM_W-1:0] m;
    do_reset();
    for (int i = 0; i < 247; i++) drive_ctx(6'(i % 3), 7'($urandom), 10'($urandom), 1'b1);
    settle();
    checks++; if ({ctx_count, ctx_afull} !== {9'd247, 1'b0}) $display("FAIL fill_247 got %0d/%b exp 247/0", ctx_count, ctx_afull); else passed++;
    drive_ctx(6'd0, 7'($urandom), 10'($urandom), 1'b1);
    settle();
    checks++; if ({ctx_count, ctx_afull} !== {9'd248, 1'b1}) $display("FAIL fill_248 got %0d/%b exp 248/1", ctx_count, ctx_afull); else passed++;
    for (int i = 0; i < 8; i++) drive_ctx(6'd2, 7'($urandom), 10'($urandom), 1'b1);
    settle();
    checks++; if ({ctx_count, err_ctx_ovf} !== {9'd256, 1'b0}) $display("FAIL fill_256 got %0d/%b exp 256/0", ctx_count, err_ctx_ovf); else passed++;
    drive_ctx(6'd1, 7'($urandom), 10'($urandom), 1'b0);
    settle();
    checks++; if ({ctx_count, err_ctx_ovf} !== {9'd256, 1'b1}) $display("FAIL fill_ovf got %0d/%b exp 256/1", ctx_count, err_ctx_ovf); else passed++;
    for (int c = 0; c < 300 && cq.size() > 0; c++) begin
      if (c < 256) begin
        mq.push_back(rnd_mem()); mem_data = mq[$]; mem_valid = 1'b1;
      end else mem_valid = 1'b0;
      tick();
      if (out_status !== BUB) begin
        e = cq.pop_front(); m = mq.pop_front();
        checks++; if ({out_status, out_query} !== {e.st, e.q}) $display("FAIL fill_stq got %h/%h exp %h/%h", out_status, out_query, e.st, e.q); else passed++;
        checks++; if (out_ctx !== e.ctx) $display("FAIL fill_ctx got %h exp %h", out_ctx, e.ctx); else passed++;
        checks++; if (out_mem !== m) $display("FAIL fill_mem got %h exp %h", out_mem, m); else passed++;
      end
    end
    mem_valid = 1'b0;
    checks++; if (cq.size() != 0) $display("FAIL fill_drain got %0d left exp 0", cq.size()); else passed++;
    checks++; if ({ctx_count, err_ctx_ovf, err_mem_ovf} !== {9'd0, 1'b1, 1'b0}) $display("FAIL fill_end got %0d/%b/%b exp 0/1/0", ctx_count, err_ctx_ovf, err_mem_ovf); else passed++;
  endtask

  task automatic test_orphan();
    exp_t e;
    logic [MEM_W-1:0] m;
    bit seen = 1'b0;
    do_reset();
    mq.push_back(rnd_mem()); mem_data = mq[$]; mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0; new_read_valid = 1'b1; load_done = 1'b1;
    #1;
    checks++; if (new_read_ack !== 1'b0) $display("FAIL orph_ack got %b exp 0", new_read_ack); else passed++;
    tick();
    checks++; if ({out_status, err_orphan} !== {BUB, 1'b1}) $display("FAIL orph_flag got %h/%b exp 30/1", out_status, err_orphan); else passed++;
    tick();
    new_read_valid = 1'b0; load_done = 1'b0;
    checks++; if (out_status !== BUB) $display("FAIL orph_hold got %h exp %h", out_status, BUB); else passed++;
    drive_ctx(6'd2, 7'd40, 10'd300, 1'b1);
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (out_status !== BUB) begin
        seen = 1'b1;
        e = cq.pop_front(); m = mq.pop_front();
        checks++; if ({out_status, out_query} !== {e.st, e.q}) $display("FAIL orph_stq got %h/%h exp %h/%h", out_status, out_query, e.st, e.q); else passed++;
        checks++; if (out_ctx !== e.ctx) $display("FAIL orph_ctx got %h exp %h", out_ctx, e.ctx); else passed++;
        checks++; if (out_mem !== m) $display("FAIL orph_mem got %h exp %h", out_mem, m); else passed++;
      end
    end
    checks++; if (!seen) $display("FAIL orph_timeout got none exp pair"); else passed++;
  endtask

  task automatic test_stall();
    exp_t e, h;
    logic [MEM_W-1:0] m, hm;
    do_reset();
    for (int i = 0; i < 6; i++) drive_ctx(6'(i % 3), 7'($urandom), 10'($urandom), 1'b1);
    settle();
    checks++; if (ctx_count !== 9'd6) $display("FAIL stall_count got %0d exp 6", ctx_count); else passed++;
    mq.push_back(rnd_mem()); mem_data = mq[$]; mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    tick();
    h = cq.pop_front(); hm = mq.pop_front();
    checks++; if ({out_status, out_query} !== {h.st, h.q}) $display("FAIL stall_p0 got %h/%h exp %h/%h", out_status, out_query, h.st, h.q); else passed++;
    stall = 1'b1; new_read_valid = 1'b1; load_done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mq.push_back(rnd_mem()); mem_data = mq[$]; mem_valid = 1'b1;
      tick();
      checks++; if ({out_status, out_query, ctx_count, new_read_ack} !== {h.st, h.q, 9'd5, 1'b0}) $display("FAIL stall_frz got %h/%h/%0d/%b exp %h/%h/5/0", out_status, out_query, ctx_count, new_read_ack, h.st, h.q); else passed++;
      checks++; if ({out_ctx, out_mem} !== {h.ctx, hm}) $display("FAIL stall_frz_data got %h exp %h", out_ctx, h.ctx); else passed++;
    end
    stall = 1'b0; mem_valid = 1'b0; new_read_valid = 1'b0; load_done = 1'b0;
    for (int c = 0; c < 20 && cq.size() > 0; c++) begin
      tick();
      if (out_status !== BUB) begin
        e = cq.pop_front(); m = mq.pop_front();
        checks++; if ({out_status, out_query} !== {e.st, e.q}) $display("FAIL stall_stq got %h/%h exp %h/%h", out_status, out_query, e.st, e.q); else passed++;
        checks++; if (out_ctx !== e.ctx) $display("FAIL stall_ctx got %h exp %h", out_ctx, e.ctx); else passed++;
        checks++; if (out_mem !== m) $display("FAIL stall_mem got %h exp %h", out_mem, m); else passed++;
      end
    end
    checks++; if (cq.size() + mq.size() != 0) $display("FAIL stall_drain got %0d left exp 0", cq.size() + mq.size()); else passed++;
    checks++; if ({err_orphan, err_mem_ovf, err_ctx_ovf} !== 3'b0) $display("FAIL stall_err got %b exp 000", {err_orphan, err_mem_ovf, err_ctx_ovf}); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    drive_ctx(6'd1, 7'd3, 10'd4, 1'b1);
    drive_ctx(6'd0, 7'd5, 10'd6, 1'b1);
    settle();
    drive_ctx(6'd2, 7'd7, 10'd8, 1'b1);
    do_reset();
    settle();
    checks++; if (ctx_count !== 9'd0) $display("FAIL flush_count got %0d exp 0", ctx_count); else passed++;
    mem_data = rnd_mem(); mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    tick();
    checks++; if ({out_status, err_orphan} !== {BUB, 1'b1}) $display("FAIL flush_orph got %h/%b exp 30/1", out_status, err_orphan); else passed++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_new_read();
    test_pair();
    test_fill();
    test_orphan();
    test_stall();
    test_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
